// File: rtl/rr_stream_arbiter_pkg.sv
// rtl/rr_stream_arbiter_pkg.sv - shared types and defaults for the round-robin stream arbiter
package rr_stream_arbiter_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   localparam int DEF_N  = 4;
   localparam int DEF_DW = 32;

endpackage

// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - lowest-set-bit priority encoder
module priority_encoder #(
   parameter int W = 4
) (
   input  logic [W-1:0]         in_vec,
   output logic [$clog2(W)-1:0] idx,
   output logic                 valid
);

   localparam int IW = $clog2(W);

   // Scan downwards so the lowest set bit is the last assignment and wins.
   always_comb begin
      idx   = '0;
      valid = |in_vec;
      for (int i = W - 1; i >= 0; i--) begin
         if (in_vec[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/rr_stream_arbiter.sv
// rtl/rr_stream_arbiter.sv - round-robin arbiter sharing one registered stream among N requesters
module rr_stream_arbiter
   import rr_stream_arbiter_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int DW = DEF_DW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req_valid,
   input  logic [N-1:0]         req_last,
   input  logic [N*DW-1:0]      req_data,
   output logic [N-1:0]         req_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        out_data,
   output logic                 out_last,
   output logic [$clog2(N)-1:0] out_src
);

   localparam int SW = $clog2(N);

   arb_state_e    state_q, state_d;
   logic [SW-1:0] ptr_q, ptr_d;
   logic [SW-1:0] lock_src_q, lock_src_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic          out_last_q, out_last_d;
   logic [SW-1:0] out_src_q, out_src_d;

   logic [N-1:0]  hi;
   logic [SW-1:0] hi_idx, raw_idx, grant_idx;
   logic          hi_vld, raw_vld, grant_valid;
   logic          load, transfer;

   // Requesters strictly above the last winner get first pick.
   always_comb begin
      hi = '0;
      for (int i = 0; i < N; i++) begin
         hi[i] = req_valid[i] && (i > int'(ptr_q));
      end
   end

   priority_encoder #(.W(N)) u_enc_hi (
      .in_vec (hi),
      .idx    (hi_idx),
      .valid  (hi_vld)
   );

   priority_encoder #(.W(N)) u_enc_raw (
      .in_vec (req_valid),
      .idx    (raw_idx),
      .valid  (raw_vld)
   );

   always_comb begin
      grant_idx   = raw_idx;
      grant_valid = raw_vld;
      if (state_q == ST_LOCKED) begin
         grant_idx   = lock_src_q;
         grant_valid = req_valid[lock_src_q];
      end else if (hi_vld) begin
         grant_idx   = hi_idx;
         grant_valid = 1'b1;
      end
   end

   assign load     = !out_valid_q || out_ready;
   assign transfer = load && grant_valid;

   always_comb begin
      req_ready = '0;
      if (transfer && !rst) req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      lock_src_d  = lock_src_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_src_d   = out_src_q;
      if (load) begin
         out_valid_d = transfer;
         if (transfer) begin
            out_data_d = req_data[int'(grant_idx)*DW +: DW];
            out_last_d = req_last[grant_idx];
            out_src_d  = grant_idx;
            ptr_d      = grant_idx;
            if (req_last[grant_idx]) begin
               state_d = ST_IDLE;
            end else begin
               state_d    = ST_LOCKED;
               lock_src_d = grant_idx;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= SW'(N - 1);
         lock_src_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_src_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         lock_src_q  <= lock_src_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb/tb_rr_stream_arbiter.sv - self-checking bench for rr_stream_arbiter
module tb_rr_stream_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_last, req_ready;
   logic [N*DW-1:0] req_data;
   logic            out_valid, out_ready, out_last;
   logic [DW-1:0]   out_data;
   logic [SW-1:0]   out_src;

   int n_cmp = 0;
   int n_bad = 0;
   bit started = 0;

   // Behavioural model state: arbitration pointer, lock owner and the output beat.
   int        m_ptr, m_lsrc, m_os;
   bit        m_lock, m_ov, m_ol;
   bit [31:0] m_od;

   rr_stream_arbiter #(.N(N), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_src   (out_src)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   // Rotating search starting just after the last winner; lock pins the owner.
   function automatic void model_grant(output bit gv, output int gi);
      gv = 0;
      gi = 0;
      if (m_lock) begin
         gi = m_lsrc;
         gv = req_valid[gi];
      end else begin
         for (int k = 1; k <= N; k++) begin
            if (!gv && req_valid[(m_ptr + k) % N]) begin
               gv = 1;
               gi = (m_ptr + k) % N;
            end
         end
      end
   endfunction

   always @(posedge clk) begin
      bit gv;
      int gi;
      started = 1;
      if (rst) begin
         m_ptr = N - 1; m_lock = 0; m_lsrc = 0;
         m_ov = 0; m_od = 0; m_ol = 0; m_os = 0;
      end else if (!m_ov || out_ready) begin
         model_grant(gv, gi);
         m_ov = gv;
         if (gv) begin
            m_od   = req_data[gi*DW +: DW];
            m_ol   = req_last[gi];
            m_os   = gi;
            m_ptr  = gi;
            m_lock = !req_last[gi];
            if (!req_last[gi]) m_lsrc = gi;
         end
      end
   end

   always @(negedge clk) begin
      bit gv;
      int gi;
      logic [N-1:0] er;
      if (started) begin
         er = '0;
         model_grant(gv, gi);
         if (!rst && (!m_ov || out_ready) && gv) er[gi] = 1'b1;
         cmp("model_req_ready", req_ready, er);
         cmp("model_out_valid", out_valid, m_ov);
         cmp("model_out_data", out_data, m_od);
         cmp("model_out_last", out_last, m_ol);
         cmp("model_out_src", out_src, m_os);
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1; req_valid = '0;
      @(posedge clk); #1;
      rst = 0;
   endtask

   int fair_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

   initial begin
      rst = 1; req_valid = '0; req_last = '1; req_data = '0; out_ready = 1;

      // Single requester after reset
      do_reset();
      req_valid = 4'b0100; req_last = 4'b1111; req_data[2*DW +: DW] = 32'hA5;
      @(negedge clk);
      cmp("reset_out_valid", out_valid, 0);
      cmp("reset_out_data", out_data, 0);
      cmp("single_req_ready", req_ready, 4'b0100);
      @(posedge clk); #1; req_valid = '0;
      @(negedge clk);
      cmp("single_out_valid", out_valid, 1);
      cmp("single_out_data", out_data, 32'hA5);
      cmp("single_out_src", out_src, 2);

      // Round-robin fairness
      do_reset();
      req_valid = 4'b1111; req_last = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); @(negedge clk);
         cmp("fair_out_src", out_src, fair_exp[c]);
      end
      @(posedge clk); #1; req_valid = '0;

      // Multi-beat lock holds off requester 0
      do_reset();
      req_valid = 4'b0010; req_last = 4'b0000;
      @(posedge clk); #1; req_valid = 4'b0011; req_last = 4'b0001;
      @(negedge clk);
      cmp("lock_ready_b2", req_ready, 4'b0010);
      cmp("lock_src_b1", out_src, 1);
      @(posedge clk); #1; req_last = 4'b0011;
      @(negedge clk);
      cmp("lock_ready_b3", req_ready, 4'b0010);
      cmp("lock_src_b2", out_src, 1);
      @(posedge clk); #1; req_valid = 4'b0001;
      @(negedge clk);
      cmp("lock_src_b3", out_src, 1);
      cmp("unlock_ready", req_ready, 4'b0001);
      @(posedge clk); #1; req_valid = '0;
      @(negedge clk);
      cmp("unlock_src", out_src, 0);

      // Backpressure
      do_reset();
      req_valid = 4'b0001; req_last = 4'b1111; req_data[0 +: DW] = 32'h11;
      @(posedge clk); #1;
      out_ready = 0; req_valid = 4'b0110;
      req_data[DW +: DW] = 32'h22; req_data[2*DW +: DW] = 32'h33;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         cmp("bp_out_valid", out_valid, 1);
         cmp("bp_out_data", out_data, 32'h11);
         cmp("bp_out_src", out_src, 0);
         cmp("bp_req_ready", req_ready, 4'b0000);
         @(posedge clk);
      end
      #1 out_ready = 1;
      @(negedge clk);
      cmp("bp_release_ready", req_ready, 4'b0010);
      @(posedge clk);
      @(negedge clk);
      cmp("bp_next_data", out_data, 32'h22);
      cmp("bp_next_src", out_src, 1);
      @(posedge clk); #1; req_valid = '0;
      @(negedge clk);
      cmp("bp_third_data", out_data, 32'h33);
      cmp("bp_third_src", out_src, 2);
      @(posedge clk);
      @(negedge clk);
      cmp("bp_drain_valid", out_valid, 0);

      // Lock bubble, then reset mid-lock
      do_reset();
      req_valid = 4'b0100; req_last = 4'b0000;
      @(posedge clk); #1; req_valid = 4'b0011; req_last = 4'b1111;
      @(negedge clk);
      cmp("bubble_ready_1", req_ready, 4'b0000);
      @(posedge clk);
      @(negedge clk);
      cmp("bubble_ready_2", req_ready, 4'b0000);
      cmp("bubble_out_valid", out_valid, 0);
      @(posedge clk); #1;
      rst = 1; req_valid = 4'b0111;
      @(negedge clk);
      cmp("reset_cycle_ready", req_ready, 4'b0000);
      @(posedge clk); #1; rst = 0;
      @(negedge clk);
      cmp("post_reset_ready", req_ready, 4'b0001);
      @(posedge clk);
      @(negedge clk);
      cmp("post_reset_src", out_src, 0);

      // Randomized traffic checked by the model every cycle
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         req_valid = 4'($urandom);
         req_last  = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
         if (c == 1500) rst = 1;
         else rst = 0;
      end

      @(posedge clk); #1; req_valid = '0;
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
